// File: rtl/id_exe_stage.sv
// ID/EXE pipeline register: latches the decoded instruction, forwards MEM/WB
// results onto the ALU operands and keeps the architectural NZCV flags.
module id_exe_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [3:0]    id_cmd,
  input  logic          id_s,
  input  logic          id_wb_en,
  input  logic          id_mem_r,
  input  logic          id_mem_w,
  input  logic [DW-1:0] id_val_rn,
  input  logic [DW-1:0] id_val2,
  input  logic [RW-1:0] id_dest,
  input  logic [3:0]    id_cond,
  input  logic [1:0]    fwd_sel_a,
  input  logic [1:0]    fwd_sel_b,
  input  logic [DW-1:0] mem_result,
  input  logic [DW-1:0] wb_result,
  input  logic [3:0]    alu_status,
  output logic          exe_valid,
  output logic [3:0]    exe_cmd,
  output logic          exe_s,
  output logic          exe_wb_en,
  output logic          exe_mem_r,
  output logic          exe_mem_w,
  output logic [RW-1:0] exe_dest,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_flush,
  output logic [3:0]    status,
  output logic          cond_pass
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [1:0] {
    FWD_REG  = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_REG2 = 2'd3
  } fwd_e;

  logic [DW-1:0] val_rn_q;
  logic [DW-1:0] val2_q;
  logic [3:0]    eff_flags;
  logic          flag_n, flag_z, flag_c, flag_v;

  // Stage register: flush only squashes the valid/side-effect bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_valid <= 1'b0;
      exe_cmd   <= '0;
      exe_s     <= 1'b0;
      exe_wb_en <= 1'b0;
      exe_mem_r <= 1'b0;
      exe_mem_w <= 1'b0;
      exe_dest  <= '0;
      val_rn_q  <= '0;
      val2_q    <= '0;
    end else if (flush) begin
      exe_valid <= 1'b0;
      exe_s     <= 1'b0;
      exe_wb_en <= 1'b0;
      exe_mem_r <= 1'b0;
      exe_mem_w <= 1'b0;
    end else if (!freeze) begin
      exe_valid <= id_valid;
      exe_cmd   <= id_cmd;
      exe_s     <= id_s;
      exe_wb_en <= id_wb_en;
      exe_mem_r <= id_mem_r;
      exe_mem_w <= id_mem_w;
      exe_dest  <= id_dest;
      val_rn_q  <= id_val_rn;
      val2_q    <= id_val2;
    end
  end

  // Flags commit only on the edge the instruction leaves execute, so a frozen
  // flag-setting instruction writes exactly once.
  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
    end else if (exe_valid && exe_s && !freeze && !flush) begin
      status <= alu_status;
    end
  end

  always_comb begin
    alu_a = val_rn_q;
    case (fwd_e'(fwd_sel_a))
      FWD_MEM: alu_a = mem_result;
      FWD_WB:  alu_a = wb_result;
      default: alu_a = val_rn_q;
    endcase
  end

  always_comb begin
    alu_b = val2_q;
    case (fwd_e'(fwd_sel_b))
      FWD_MEM: alu_b = mem_result;
      FWD_WB:  alu_b = wb_result;
      default: alu_b = val2_q;
    endcase
  end

  assign alu_flush = ~exe_valid;

  // Bypass lets decode see flags from a flag-setting instruction still in execute.
  assign eff_flags = (exe_valid && exe_s) ? alu_status : status;
  assign flag_n    = eff_flags[3];
  assign flag_z    = eff_flags[2];
  assign flag_c    = eff_flags[1];
  assign flag_v    = eff_flags[0];

  always_comb begin
    cond_pass = 1'b0;
    case (cond_e'(id_cond))
      COND_EQ: cond_pass = flag_z;
      COND_NE: cond_pass = ~flag_z;
      COND_CS: cond_pass = flag_c;
      COND_CC: cond_pass = ~flag_c;
      COND_MI: cond_pass = flag_n;
      COND_PL: cond_pass = ~flag_n;
      COND_VS: cond_pass = flag_v;
      COND_VC: cond_pass = ~flag_v;
      COND_HI: cond_pass = flag_c & ~flag_z;
      COND_LS: cond_pass = ~flag_c | flag_z;
      COND_GE: cond_pass = (flag_n == flag_v);
      COND_LT: cond_pass = (flag_n != flag_v);
      COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_pass = flag_z | (flag_n != flag_v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

endmodule
